// File: rtl/glitch_sequencer_if.sv
// Host/trigger-side bundle for glitch_sequencer: arm/abort/trigger inputs,
// pattern configuration and status outputs.
interface glitch_sequencer_if #(
  parameter int DLY_W = 24,
  parameter int WID_W = 12,
  parameter int GAP_W = 12,
  parameter int CNT_W = 8
);
  logic             arm;
  logic             abort;
  logic             trigger_in;
  logic [DLY_W-1:0] cfg_delay;
  logic [WID_W-1:0] cfg_width;
  logic [GAP_W-1:0] cfg_gap;
  logic [CNT_W-1:0] cfg_count;
  logic             glitch_out;
  logic             armed;
  logic             busy;
  logic             done;
  logic             timeout;
  logic             led_out;

  modport master (
    output arm, abort, trigger_in, cfg_delay, cfg_width, cfg_gap, cfg_count,
    input  glitch_out, armed, busy, done, timeout, led_out
  );

  modport slave (
    input  arm, abort, trigger_in, cfg_delay, cfg_width, cfg_gap, cfg_count,
    output glitch_out, armed, busy, done, timeout, led_out
  );
endinterface

// File: rtl/glitch_sequencer.sv
// One-shot glitch pattern sequencer: after a synchronised trigger rising edge,
// waits a programmed delay then emits count pulses of width separated by gap.
module glitch_sequencer #(
  parameter int DLY_W       = 24,
  parameter int WID_W       = 12,
  parameter int GAP_W       = 12,
  parameter int CNT_W       = 8,
  parameter int ARM_TIMEOUT = 0,
  parameter int TO_W        = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  glitch_sequencer_if.slave    bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    DELAY = 3'd2,
    PULSE = 3'd3,
    GAP   = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam bit            TO_EN   = (ARM_TIMEOUT > 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ARM_TIMEOUT - 1);

  state_t           state_r, next_s;
  logic             ff1_r, ff2_r, prev_r;
  logic             trig_rise_s, to_expire_s;
  logic [DLY_W-1:0] dly_lat_r, dly_ctr_r;
  logic [WID_W-1:0] wid_lat_r, wid_ctr_r;
  logic [GAP_W-1:0] gap_lat_r, gap_ctr_r;
  logic [CNT_W-1:0] cnt_lat_r, pls_ctr_r;
  logic [TO_W-1:0]  to_ctr_r;
  logic             glitch_r, armed_r, busy_r, done_r, timeout_r;

  assign trig_rise_s = ff2_r & ~prev_r;
  assign to_expire_s = TO_EN && (to_ctr_r == TO_LAST);

  // Two-flop synchroniser plus edge history, tracked in every state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff1_r  <= 1'b0;
      ff2_r  <= 1'b0;
      prev_r <= 1'b0;
    end else begin
      ff1_r  <= bus.trigger_in;
      ff2_r  <= ff1_r;
      prev_r <= ff2_r;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state decode; abort overrides every transition
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE:    next_s = bus.arm ? ARMED : IDLE;
      ARMED: begin
        if (trig_rise_s) begin
          next_s = (dly_lat_r == '0) ? PULSE : DELAY;
        end else if (to_expire_s) begin
          next_s = IDLE;
        end else begin
          next_s = ARMED;
        end
      end
      DELAY:   next_s = (dly_ctr_r == DLY_W'(1)) ? PULSE : DELAY;
      PULSE: begin
        if (wid_ctr_r == WID_W'(1)) begin
          next_s = (pls_ctr_r == CNT_W'(1)) ? DONE : GAP;
        end else begin
          next_s = PULSE;
        end
      end
      GAP:     next_s = (gap_ctr_r == GAP_W'(1)) ? PULSE : GAP;
      DONE:    next_s = IDLE;
      default: next_s = IDLE;
    endcase
    if (bus.abort) begin
      next_s = IDLE;
    end else begin
      next_s = next_s;
    end
  end

  // Config latch and pattern counters; each loads on entry to its state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dly_lat_r <= '0;
      wid_lat_r <= '0;
      gap_lat_r <= '0;
      cnt_lat_r <= '0;
      dly_ctr_r <= '0;
      wid_ctr_r <= '0;
      gap_ctr_r <= '0;
      pls_ctr_r <= '0;
      to_ctr_r  <= '0;
    end else begin
      if (state_r == IDLE && next_s == ARMED) begin
        dly_lat_r <= bus.cfg_delay;
        wid_lat_r <= (bus.cfg_width == '0) ? WID_W'(1) : bus.cfg_width;
        gap_lat_r <= (bus.cfg_gap   == '0) ? GAP_W'(1) : bus.cfg_gap;
        cnt_lat_r <= (bus.cfg_count == '0) ? CNT_W'(1) : bus.cfg_count;
      end
      if (TO_EN && state_r == ARMED && next_s == ARMED) begin
        to_ctr_r <= to_ctr_r + TO_W'(1);
      end else begin
        to_ctr_r <= '0;
      end
      if (state_r == ARMED && next_s == DELAY) begin
        dly_ctr_r <= dly_lat_r;
      end else if (state_r == DELAY && dly_ctr_r != '0) begin
        dly_ctr_r <= dly_ctr_r - DLY_W'(1);
      end
      if (next_s == PULSE && state_r != PULSE) begin
        wid_ctr_r <= wid_lat_r;
      end else if (state_r == PULSE && wid_ctr_r != '0) begin
        wid_ctr_r <= wid_ctr_r - WID_W'(1);
      end
      if (next_s == GAP && state_r != GAP) begin
        gap_ctr_r <= gap_lat_r;
      end else if (state_r == GAP && gap_ctr_r != '0) begin
        gap_ctr_r <= gap_ctr_r - GAP_W'(1);
      end
      if (state_r == ARMED && (next_s == DELAY || next_s == PULSE)) begin
        pls_ctr_r <= cnt_lat_r;
      end else if (state_r == PULSE && next_s == GAP) begin
        pls_ctr_r <= pls_ctr_r - CNT_W'(1);
      end
    end
  end

  // Output flops decoded from the upcoming state so they align with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      glitch_r  <= 1'b0;
      armed_r   <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      glitch_r  <= (next_s == PULSE);
      armed_r   <= (next_s == ARMED);
      busy_r    <= (next_s == ARMED) || (next_s == DELAY) ||
                   (next_s == PULSE) || (next_s == GAP);
      done_r    <= (next_s == DONE);
      timeout_r <= (state_r == ARMED) && to_expire_s && !trig_rise_s && !bus.abort;
    end
  end

  assign bus.glitch_out = glitch_r;
  assign bus.armed      = armed_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.timeout    = timeout_r;
  assign bus.led_out    = busy_r;

endmodule

// File: tb/tb_glitch_sequencer.sv
// Randomised and directed bench for glitch_sequencer; expected outputs come
// from an edge-arithmetic model of the pattern timeline.
module tb_glitch_sequencer;
  localparam int DLY_W = 24, WID_W = 12, GAP_W = 12, CNT_W = 8;
  localparam int ARM_TIMEOUT = 50, TO_W = 32;
  localparam int NONE = -100000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  glitch_sequencer_if #(.DLY_W(DLY_W), .WID_W(WID_W), .GAP_W(GAP_W), .CNT_W(CNT_W)) bus ();

  glitch_sequencer #(
    .DLY_W(DLY_W), .WID_W(WID_W), .GAP_W(GAP_W), .CNT_W(CNT_W),
    .ARM_TIMEOUT(ARM_TIMEOUT), .TO_W(TO_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {bus.glitch_out, bus.armed, bus.busy, bus.done, bus.timeout, bus.led_out};
  endfunction

  // Expected {glitch, armed, busy, done, timeout, led} in the cycle after edge e.
  function automatic logic [5:0] model(input int e, input int a, input int k, input int b,
                                       input bit fire, input int d, input int wi,
                                       input int gi, input int ni);
    logic gl, ar, bs, dn, to;
    int s0, dn_e;
    gl = 1'b0; ar = 1'b0; bs = 1'b0; dn = 1'b0; to = 1'b0;
    if (e >= a && e < b) begin
      if (fire) begin
        s0   = k + 2 + d;
        dn_e = s0 + (ni - 1) * (wi + gi) + wi;
        ar   = (e < k + 2);
        for (int i = 0; i < ni; i++) begin
          if (e >= s0 + i * (wi + gi) && e < s0 + i * (wi + gi) + wi) gl = 1'b1;
        end
        bs = (e < dn_e);
        dn = (e == dn_e);
      end else begin
        ar = (e < a + ARM_TIMEOUT);
        bs = ar;
        to = (e == a + ARM_TIMEOUT);
      end
    end
    return {gl, ar, bs, dn, to, bs};
  endfunction

  // trig_off/abort_off/rst_off are edge offsets relative to the arm edge.
  task automatic run_seq(input int d, input int w, input int g, input int n,
                         input int trig_off, input int abort_off, input int rst_off);
    int a, k, b, rb, wi, gi, ni, end_e;
    bit has_trig, fire;
    wi = (w == 0) ? 1 : w;
    gi = (g == 0) ? 1 : g;
    ni = (n == 0) ? 1 : n;
    @(negedge clk);
    a        = cyc + 6;
    has_trig = (trig_off != NONE);
    k        = has_trig ? a + trig_off : 1 << 30;
    b        = (abort_off != NONE) ? a + abort_off : 1 << 30;
    rb       = (rst_off != NONE) ? a + rst_off : 1 << 30;
    fire     = has_trig && (k + 1 >= a) && (k + 2 <= a + ARM_TIMEOUT);
    end_e    = fire ? k + 2 + d + (ni - 1) * (wi + gi) + wi + 3 : a + ARM_TIMEOUT + 3;
    if (b + 3 < end_e) end_e = b + 3;
    if (rb < end_e) end_e = rb;
    bus.cfg_delay = DLY_W'(d);
    bus.cfg_width = WID_W'(w);
    bus.cfg_gap   = GAP_W'(g);
    bus.cfg_count = CNT_W'(n);
    for (int e = cyc + 1; e <= end_e; e++) begin
      bus.arm        = (e == a);
      bus.abort      = (e == b);
      bus.trigger_in = has_trig && (e >= k);
      if (e > a) begin
        bus.cfg_delay = DLY_W'($urandom);
        bus.cfg_width = WID_W'($urandom);
        bus.cfg_gap   = GAP_W'($urandom);
        bus.cfg_count = CNT_W'($urandom);
      end
      @(posedge clk);
      #1;
      check($sformatf("outs d%0d w%0d g%0d n%0d rel%0d", d, w, g, n, e - a),
            32'(outs()), 32'(model(e, a, k, b, fire, d, wi, gi, ni)));
      if (e == rb) begin
        #2 rst = 1'b1;
        #1 check("rst_async", 32'(outs()), 32'd0);
        @(negedge clk);
        rst = 1'b0;
      end
      @(negedge clk);
    end
    bus.arm        = 1'b0;
    bus.abort      = 1'b0;
    bus.trigger_in = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    bus.arm = 1'b0; bus.abort = 1'b0; bus.trigger_in = 1'b0;
    bus.cfg_delay = '0; bus.cfg_width = '0; bus.cfg_gap = '0; bus.cfg_count = '0;
    #1 check("reset_state", 32'(outs()), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", 32'(outs()), 32'd0);

    run_seq(10, 3, 0, 1, 20, NONE, NONE);
    run_seq(0, 0, 0, 0, 10, NONE, NONE);
    run_seq(5, 2, 4, 3, 10, NONE, NONE);
    run_seq(3, 2, 1, 1, -4, NONE, NONE);      // trigger already high at arm
    run_seq(3, 2, 1, 1, 5, NONE, NONE);       // fresh rising edge fires
    run_seq(4, 2, 2, 1, NONE, NONE, NONE);    // pure timeout
    run_seq(4, 2, 2, 1, 48, NONE, NONE);      // rise on expiry cycle wins
    run_seq(4, 2, 2, 1, 49, NONE, NONE);      // rise one cycle late
    run_seq(0, 0, 0, 1, -1, NONE, NONE);      // rise in first ARMED cycle
    run_seq(2, 100, 1, 1, 5, 49, NONE);       // abort mid long pulse
    run_seq(1, 1, 1, 1, 5, 0, NONE);          // abort with arm
    run_seq(2, 3, 20, 2, 5, NONE, 15);        // async reset during gap
    run_seq(2, 2, 2, 2, 5, NONE, NONE);       // normal run after reset

    for (int r = 0; r < 25; r++) begin
      int t_off, a_off;
      t_off = $urandom_range(0, 9) == 0 ? NONE : int'($urandom_range(0, 58)) - 5;
      a_off = $urandom_range(0, 4) == 0 ? int'($urandom_range(0, 40)) : NONE;
      run_seq(int'($urandom_range(0, 20)), int'($urandom_range(0, 5)),
              int'($urandom_range(0, 5)), int'($urandom_range(0, 4)),
              t_off, a_off, NONE);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/glitch_sequencer.md
Name: glitch_sequencer

Overview:
Sequences the fault-injection glitch once the smartcard I/O edge-count trigger fires. Software arms the block with a delay, pulse width, pulse count and inter-pulse gap. On the trigger's rising edge the block waits the programmed delay in clk cycles, then drives the glitch MOSFET/crowbar output for the programmed pattern. It sits between the I/O-edge trigger detector and the glitch driver pin, and exposes busy/done/timeout status to the host register interface.

Parameters:
DLY_W, 24, width of cfg_delay and delay counter
WID_W, 12, width of cfg_width and pulse-width counter
GAP_W, 12, width of cfg_gap and gap counter
CNT_W, 8, width of cfg_count and pulse counter
ARM_TIMEOUT, 0, cycles allowed in ARMED before auto-disarm; 0 disables timeout
TO_W, 32, width of timeout counter

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
arm  input  1  one-cycle arm request; latches cfg_* when in IDLE
abort  input  1  force return to IDLE from any state
trigger_in  input  1  asynchronous trigger from I/O edge counter (level, rising edge is the event)
cfg_delay  input  DLY_W  cycles from detected trigger to first pulse
cfg_width  input  WID_W  pulse high time in cycles (0 treated as 1)
cfg_gap  input  GAP_W  low time between pulses in cycles (0 treated as 1)
cfg_count  input  CNT_W  number of pulses (0 treated as 1)
glitch_out  output  1  registered glitch drive, high only in PULSE
armed  output  1  high while in ARMED
busy  output  1  high in ARMED, DELAY, PULSE, GAP
done  output  1  one-cycle pulse on pattern completion
timeout  output  1  one-cycle pulse on ARM_TIMEOUT expiry
led_out  output  1  equals busy

Behaviour:
- Reset: state=IDLE, all counters 0, sync flops 0, glitch_out/armed/busy/done/timeout/led_out = 0.
- Trigger sync: trigger_in -> ff1 -> ff2; prev <= ff2; trig_rise = ff2 & ~prev. If trigger_in is first sampled high at edge k, trig_rise is true during cycle after edge k+1.
- States: IDLE, ARMED, DELAY, PULSE, GAP, DONE. All outputs decoded from registered state or registered pulse flops.
- IDLE: arm=1 -> ARMED; latch cfg_* (zero width/gap/count substituted with 1). arm in any other state ignored; cfg changes after arm have no effect.
- ARMED: trig_rise -> DELAY with dly_ctr=cfg_delay (at edge k+2); if cfg_delay==0 go directly to PULSE. A trigger already high at arm time does not fire; a new rising edge is required (prev tracked continuously, including in IDLE).
- DELAY: decrement each cycle; at dly_ctr==1 -> PULSE. First glitch_out high cycle begins at edge k+2+cfg_delay.
- PULSE: glitch_out=1 for exactly width cycles; on the last, if pulses emitted == count -> DONE, else -> GAP.
- GAP: glitch_out=0 for exactly gap cycles, then PULSE.
- DONE: done=1 for one cycle, then IDLE.
- Triggers outside ARMED ignored; pattern is one-shot per arm.
- Timeout: if ARM_TIMEOUT>0 and ARMED lasts ARM_TIMEOUT cycles without trig_rise -> IDLE, timeout=1 one cycle. trig_rise on the expiry cycle wins (goes to DELAY, no timeout).
- abort: highest priority in every state; next state IDLE, glitch_out low from the next edge, no done/timeout pulse. abort and arm same cycle in IDLE: stays IDLE.
- Async rst mid-pulse drops glitch_out immediately.
- Counters never wrap: all loads are from latched config, all decrements stop at terminal state transition.

Test Plan:
- Arm with delay=10,width=3,count=1; trigger rises sampled at edge 100 -> glitch_out high edges 112..114 (3 cycles), done at cycle after edge 115, busy low after.
- delay=0,width=0,count=0 -> single 1-cycle pulse at edge k+2; done one cycle later.
- delay=5,width=2,gap=4,count=3 -> pulses high 2, low 4, high 2, low 4, high 2; exactly 3 pulses, then done.
- trigger_in already high when arm asserted and held high -> no glitch; drop and re-raise -> sequence runs normally.
- ARM_TIMEOUT=50, no trigger -> armed for 50 cycles, timeout pulse, IDLE; second run with trigger at cycle 50 exactly -> DELAY, no timeout.
- abort asserted mid-PULSE of width=100 -> glitch_out low next edge, IDLE, no done; async rst during GAP -> all outputs 0 immediately.
